lcd_text_formatter: RTL and testbench

LCD_TEXT_FORMATTER -- requirements
Module: lcd_text_formatter

---
 rtl/lcd_text_formatter_if.sv | 22 ++
 rtl/lcd_text_formatter.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_text_formatter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_formatter_if.sv
// Character handshake between the text formatter and the LCD driver.
// The formatter drives data/pos/valid and the driver answers with ready.
interface lcd_text_formatter_if;
  logic [7:0] char_data;
  logic [4:0] char_pos;
  logic       char_valid;
  logic       char_ready;

  modport master (
    output char_data,
    output char_pos,
    output char_valid,
    input  char_ready
  );

  modport slave (
    input  char_data,
    input  char_pos,
    input  char_valid,
    output char_ready
  );
endinterface

// File: rtl/lcd_text_formatter.sv
// Formats a committed instruction into a 2x16 LCD frame, one char per handshake.
// Define FMT_HEX_EN to append the raw value as "0xHHHH" on line 2.
module lcd_text_formatter (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        update_in,
  input  logic [2:0]                  opcode_in,
  input  logic [3:0]                  reg_index_in,
  input  logic [15:0]                 reg_value_in,
  lcd_text_formatter_if.master        lcd,
  output logic                        busy,
  output logic                        frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    EMIT,
    PENDING_CHK
  } state_t;

  state_t      state_q, state_d;

  logic        upd_q;
  logic        armed_q;
  logic        rise;

  logic [2:0]  op_q, sop_q;
  logic [3:0]  idx_q, sidx_q;
  logic [15:0] val_q, sval_q;
  logic        pending_q;

  logic [15:0] sh_q;
  logic [19:0] bcd_q;
  logic [19:0] adj;
  logic [3:0]  cnt_q;
  logic [4:0]  pos_q;
  logic        done_q;

  logic        start_new;
  logic        start_pend;
  logic        accept;
  logic        last;
  logic [15:0] ld_val;
  logic [15:0] ld_mag;

  logic        valid;
  logic [7:0]  ch;
  logic [31:0] mn;
  logic [3:0]  col;
  logic [3:0]  ones;

  // armed_q blocks a level held high across reset release
  assign rise       = update_in & ~upd_q & armed_q;
  assign start_new  = (state_q == IDLE) & rise;
  assign start_pend = (state_q == PENDING_CHK) & pending_q;
  assign accept     = (state_q == EMIT) & lcd.char_ready;
  assign last       = accept & (pos_q == 5'd31);

  assign ld_val = start_pend ? sval_q : reg_value_in;
  assign ld_mag = ld_val[15] ? (~ld_val + 16'd1) : ld_val;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (rise) state_d = CONVERT;
      CONVERT:     if (cnt_q == 4'd15) state_d = EMIT;
      EMIT:        if (last) state_d = PENDING_CHK;
      PENDING_CHK: state_d = pending_q ? CONVERT : IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    busy  = 1'b0;
    unique case (state_q)
      IDLE:        busy = 1'b0;
      CONVERT:     busy = 1'b1;
      EMIT: begin
        valid = 1'b1;
        busy  = 1'b1;
      end
      PENDING_CHK: busy = 1'b1;
      default:     busy = 1'b0;
    endcase
  end

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      upd_q     <= 1'b0;
      armed_q   <= 1'b0;
      op_q      <= '0;
      idx_q     <= '0;
      val_q     <= '0;
      sop_q     <= '0;
      sidx_q    <= '0;
      sval_q    <= '0;
      pending_q <= 1'b0;
      sh_q      <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      pos_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      upd_q   <= update_in;
      armed_q <= armed_q | ~update_in;
      done_q  <= last;
      if (start_new | start_pend) begin
        op_q  <= start_pend ? sop_q : opcode_in;
        idx_q <= start_pend ? sidx_q : reg_index_in;
        val_q <= ld_val;
        sh_q  <= ld_mag;
        bcd_q <= '0;
        cnt_q <= '0;
      end else if (state_q == CONVERT) begin
        bcd_q <= {adj[18:0], sh_q[15]};
        sh_q  <= {sh_q[14:0], 1'b0};
        cnt_q <= cnt_q + 4'd1;
      end
      if (accept) pos_q <= pos_q + 5'd1;
      // a new edge beats the clear so a request is never dropped
      if (rise & (state_q != IDLE)) begin
        pending_q <= 1'b1;
        sop_q     <= opcode_in;
        sidx_q    <= reg_index_in;
        sval_q    <= reg_value_in;
      end else if (start_pend) begin
        pending_q <= 1'b0;
      end
    end
  end

`ifdef FMT_HEX_EN
  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction
`endif

  assign col  = pos_q[3:0];
  assign ones = (idx_q >= 4'd10) ? (idx_q - 4'd10) : idx_q;

  always_comb begin
    mn = "----";
    unique case (op_q)
      3'd0:    mn = "LOAD";
      3'd1:    mn = "ADD ";
      3'd2:    mn = "ADDI";
      3'd3:    mn = "SUB ";
      3'd4:    mn = "SUBI";
      3'd5:    mn = "MUL ";
      3'd6:    mn = "CLR ";
      default: mn = "----";
    endcase
  end

  always_comb begin
    ch = 8'h20;
    if (!pos_q[4]) begin
      case (col)
        4'd0:    ch = mn[31:24];
        4'd1:    ch = mn[23:16];
        4'd2:    ch = mn[15:8];
        4'd3:    ch = mn[7:0];
        4'd5:    ch = "R";
        4'd6:    ch = (idx_q >= 4'd10) ? "1" : "0";
        4'd7:    ch = 8'h30 + {4'd0, ones};
        default: ch = 8'h20;
      endcase
    end else begin
      case (col)
        4'd0:    ch = val_q[15] ? "-" : "+";
        4'd1:    ch = 8'h30 + {4'd0, bcd_q[19:16]};
        4'd2:    ch = 8'h30 + {4'd0, bcd_q[15:12]};
        4'd3:    ch = 8'h30 + {4'd0, bcd_q[11:8]};
        4'd4:    ch = 8'h30 + {4'd0, bcd_q[7:4]};
        4'd5:    ch = 8'h30 + {4'd0, bcd_q[3:0]};
`ifdef FMT_HEX_EN
        4'd10:   ch = "0";
        4'd11:   ch = "x";
        4'd12:   ch = hex_ch(val_q[15:12]);
        4'd13:   ch = hex_ch(val_q[11:8]);
        4'd14:   ch = hex_ch(val_q[7:4]);
        4'd15:   ch = hex_ch(val_q[3:0]);
`endif
        default: ch = 8'h20;
      endcase
    end
  end

  assign lcd.char_valid = valid;
  assign lcd.char_pos   = pos_q;
  assign lcd.char_data  = valid ? ch : 8'h20;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_lcd_text_formatter.sv
// Directed bench for lcd_text_formatter; define FMT_HEX_EN to match a hex build.
// A negedge monitor captures accepted characters and handshake anomalies.
`ifdef FMT_HEX_EN
`define L2(d, h) {d, "    0x", h}
`else
`define L2(d, h) {d, "          "}
`endif

module tb_lcd_text_formatter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        update_in = 1'b0;
  logic [2:0]  opcode_in = '0;
  logic [3:0]  reg_index_in = '0;
  logic [15:0] reg_value_in = '0;
  logic        busy;
  logic        frame_done;

  lcd_text_formatter_if lcd ();

  lcd_text_formatter dut (
    .clock        (clock),
    .reset        (reset),
    .update_in    (update_in),
    .opcode_in    (opcode_in),
    .reg_index_in (reg_index_in),
    .reg_value_in (reg_value_in),
    .lcd          (lcd.master),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap [32];
  int         cnt [32];
  int         frames = 0;
  int         dones = 0;
  int         total_acc = 0;
  int         mon_err = 0;
  string      l1_got = "";
  string      l2_got = "";

  initial begin
    logic [4:0] pos_exp;
    logic       stall_pend;
    logic [7:0] sd;
    logic [4:0] sp;
    logic       exp_done;
    pos_exp = '0;
    stall_pend = 1'b0;
    exp_done = 1'b0;
    sd = '0;
    sp = '0;
    for (int i = 0; i < 32; i++) cnt[i] = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        pos_exp = '0;
        stall_pend = 1'b0;
        exp_done = 1'b0;
        for (int i = 0; i < 32; i++) cnt[i] = 0;
      end else begin
        if (frame_done) dones++;
        if (frame_done != exp_done) mon_err++;
        exp_done = 1'b0;
        if (stall_pend) begin
          if (!lcd.char_valid || lcd.char_data != sd || lcd.char_pos != sp) mon_err++;
          stall_pend = 1'b0;
        end
        if (lcd.char_valid && !lcd.char_ready) begin
          stall_pend = 1'b1;
          sd = lcd.char_data;
          sp = lcd.char_pos;
        end
        if (lcd.char_valid && lcd.char_ready) begin
          if (lcd.char_pos != pos_exp) mon_err++;
          cap[lcd.char_pos] = lcd.char_data;
          cnt[lcd.char_pos]++;
          total_acc++;
          pos_exp = pos_exp + 5'd1;
          if (lcd.char_pos == 5'd31) begin
            for (int i = 0; i < 32; i++) begin
              if (cnt[i] != 1) mon_err++;
              cnt[i] = 0;
            end
            l1_got = "";
            l2_got = "";
            for (int i = 0; i < 16; i++) l1_got = $sformatf("%s%c", l1_got, cap[i]);
            for (int i = 16; i < 32; i++) l2_got = $sformatf("%s%c", l2_got, cap[i]);
            frames++;
            exp_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (frames < target && n < 3000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (frames < target) begin
      errors++;
      $display("FAIL %s: frames=%0d required %0d (timeout)", name, frames, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b required 0 (timeout)", name, busy);
    end
  endtask

  task automatic start_frame(input logic [2:0] op, input logic [3:0] idx,
                             input logic [15:0] val);
    @(posedge clock);
    #2;
    opcode_in = op;
    reg_index_in = idx;
    reg_value_in = val;
    update_in = 1'b1;
    @(posedge clock);
    #2;
    update_in = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_reset();
    lcd.char_ready = 1'b1;
    update_in = 1'b0;
    do_reset();
    #1;
    checks += 5;
    if (lcd.char_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b required 0", lcd.char_valid);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b required 0", frame_done);
    end
    if (lcd.char_data !== 8'h20) begin
      errors++;
      $display("FAIL reset_data: got %h required 20", lcd.char_data);
    end
    if (lcd.char_pos !== 5'd0) begin
      errors++;
      $display("FAIL reset_pos: got %0d required 0", lcd.char_pos);
    end
  endtask

  task automatic test_basic();
    int f0 = frames;
    int d0 = dones;
    int e0 = mon_err;
    int lat = 0;
    string e2 = `L2("+00005", "0005");
    lcd.char_ready = 1'b1;
    start_frame(3'd0, 4'd3, 16'h0005);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b required 1", busy);
    end
    // 16 more edges after the sampling edge: valid in the 17th cycle
    while (!lcd.char_valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 16) begin
      errors++;
      $display("FAIL basic_latency: got %0d required 16", lat);
    end
    wait_frames(f0 + 1, "basic_frame");
    checks += 2;
    if (l1_got != "LOAD R03        ") begin
      errors++;
      $display("FAIL basic_l1: got \"%s\" required \"LOAD R03        \"", l1_got);
    end
    if (l2_got != e2) begin
      errors++;
      $display("FAIL basic_l2: got \"%s\" required \"%s\"", l2_got, e2);
    end
    wait_idle("basic_idle");
    checks += 2;
    if (dones - d0 !== 1) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses required 1", dones - d0);
    end
    if (mon_err !== e0) begin
      errors++;
      $display("FAIL basic_handshake: got %0d anomalies required 0", mon_err - e0);
    end
  endtask

  task automatic test_values();
    logic [2:0]  ops [3] = '{3'd3, 3'd6, 3'd4};
    logic [3:0]  ids [3] = '{4'd15, 4'd0, 4'd10};
    logic [15:0] vls [3] = '{16'hFFFF, 16'h8000, 16'h7FFF};
    string e1 [3] = '{"SUB  R15        ", "CLR  R00        ", "SUBI R10        "};
    string e2 [3];
    e2[0] = `L2("-00001", "FFFF");
    e2[1] = `L2("-32768", "8000");
    e2[2] = `L2("+32767", "7FFF");
    lcd.char_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int f0 = frames;
      start_frame(ops[k], ids[k], vls[k]);
      wait_frames(f0 + 1, "values_frame");
      checks += 2;
      if (l1_got != e1[k]) begin
        errors++;
        $display("FAIL values_l1[%0d]: got \"%s\" required \"%s\"", k, l1_got, e1[k]);
      end
      if (l2_got != e2[k]) begin
        errors++;
        $display("FAIL values_l2[%0d]: got \"%s\" required \"%s\"", k, l2_got, e2[k]);
      end
      wait_idle("values_idle");
    end
  endtask

  task automatic test_stall();
    int f0 = frames;
    int e0 = mon_err;
    int a0 = total_acc;
    int c = 0;
    string e2 = `L2("+00000", "0000");
    lcd.char_ready = 1'b0;
    start_frame(3'd5, 4'd9, 16'h0000);
    while (frames == f0 && c < 1000) begin
      @(posedge clock);
      #2;
      lcd.char_ready = (c % 3 == 0);
      c++;
    end
    lcd.char_ready = 1'b1;
    wait_frames(f0 + 1, "stall_frame");
    wait_idle("stall_idle");
    checks += 4;
    if (l1_got != "MUL  R09        ") begin
      errors++;
      $display("FAIL stall_l1: got \"%s\" required \"MUL  R09        \"", l1_got);
    end
    if (l2_got != e2) begin
      errors++;
      $display("FAIL stall_l2: got \"%s\" required \"%s\"", l2_got, e2);
    end
    if (total_acc - a0 !== 32) begin
      errors++;
      $display("FAIL stall_count: got %0d accepts required 32", total_acc - a0);
    end
    if (mon_err !== e0) begin
      errors++;
      $display("FAIL stall_stable: got %0d anomalies required 0", mon_err - e0);
    end
  endtask

  task automatic test_pending();
    int f0 = frames;
    int d0 = dones;
    string ea = `L2("+00100", "0064");
    string eb = `L2("+00020", "0014");
    lcd.char_ready = 1'b1;
    start_frame(3'd1, 4'd1, 16'd100);
    start_frame(3'd2, 4'd2, 16'd10);
    start_frame(3'd3, 4'd3, 16'd20);
    wait_frames(f0 + 1, "pending_first");
    checks += 2;
    if (l1_got != "ADD  R01        ") begin
      errors++;
      $display("FAIL pending_l1a: got \"%s\" required \"ADD  R01        \"", l1_got);
    end
    if (l2_got != ea) begin
      errors++;
      $display("FAIL pending_l2a: got \"%s\" required \"%s\"", l2_got, ea);
    end
    wait_frames(f0 + 2, "pending_second");
    checks += 2;
    if (l1_got != "SUB  R03        ") begin
      errors++;
      $display("FAIL pending_l1b: got \"%s\" required \"SUB  R03        \"", l1_got);
    end
    if (l2_got != eb) begin
      errors++;
      $display("FAIL pending_l2b: got \"%s\" required \"%s\"", l2_got, eb);
    end
    repeat (80) @(posedge clock);
    checks += 2;
    if (dones - d0 !== 2) begin
      errors++;
      $display("FAIL pending_done: got %0d pulses required 2", dones - d0);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL pending_idle: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int a0;
    int seen = 0;
    lcd.char_ready = 1'b1;
    start_frame(3'd2, 4'd7, 16'd1234);
    while (!(lcd.char_valid && lcd.char_pos == 5'd12) && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (lcd.char_pos !== 5'd12) begin
      errors++;
      $display("FAIL midrst_reach: got pos %0d required 12", lcd.char_pos);
    end
    #1;
    reset = 1'b0;
    update_in = 1'b1;
    @(posedge clock);
    #1;
    a0 = total_acc;
    checks++;
    if (lcd.char_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_valid: got %b required 0", lcd.char_valid);
    end
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (lcd.char_valid || busy) seen++;
    end
    update_in = 1'b0;
    checks += 3;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrst_held: got %0d active cycles required 0", seen);
    end
    if (total_acc !== a0) begin
      errors++;
      $display("FAIL midrst_chars: got %0d extra chars required 0", total_acc - a0);
    end
    if (lcd.char_pos !== 5'd0) begin
      errors++;
      $display("FAIL midrst_pos: got %0d required 0", lcd.char_pos);
    end
  endtask

  task automatic test_hex();
    int f0 = frames;
    string e2 = `L2("-16657", "BEEF");
    lcd.char_ready = 1'b1;
    repeat (2) @(posedge clock);
    start_frame(3'd7, 4'd12, 16'hBEEF);
    wait_frames(f0 + 1, "hex_frame");
    checks += 2;
    if (l1_got != "---- R12        ") begin
      errors++;
      $display("FAIL hex_l1: got \"%s\" required \"---- R12        \"", l1_got);
    end
    if (l2_got != e2) begin
      errors++;
      $display("FAIL hex_l2: got \"%s\" required \"%s\"", l2_got, e2);
    end
    wait_idle("hex_idle");
  endtask

  initial begin
    lcd.char_ready = 1'b1;
    test_reset();
    test_basic();
    test_values();
    test_stall();
    test_pending();
    test_reset_mid();
    test_hex();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
